// File: rtl/sobel_pkg.sv
// Shared widths, kernel/FSM enums and the signed sum type for the Sobel edge filter.
package sobel_pkg;

  localparam int PIX_W   = 12;
  localparam int COORD_W = 11;
  localparam int SUM_W   = PIX_W + 4;
  localparam int PIX_MAX = 4095;

  typedef enum logic {KER_GX, KER_GY} ker_sel_t;
  typedef enum logic {WAIT_SOF, RUN} state_t;

  typedef logic signed [SUM_W-1:0] sum_t;

endpackage

// File: rtl/sobel_if.sv
// Pixel stream in/out of the Sobel filter: grey pixel + coordinates + kernel select
// on the input side, gradient magnitude + coordinates on the output side.
interface sobel_if;
  import sobel_pkg::*;

  logic [COORD_W-1:0] iX_Cont;
  logic [COORD_W-1:0] iY_Cont;
  logic [PIX_W-1:0]   iDATA;
  logic               iDVAL;
  logic               iSel;
  logic [PIX_W-1:0]   oDATA;
  logic [COORD_W-1:0] oX_Cont;
  logic [COORD_W-1:0] oY_Cont;
  logic               oDVAL;

  modport slave (
    input  iX_Cont, iY_Cont, iDATA, iDVAL, iSel,
    output oDATA, oX_Cont, oY_Cont, oDVAL
  );

  modport master (
    output iX_Cont, iY_Cont, iDATA, iDVAL, iSel,
    input  oDATA, oX_Cont, oY_Cont, oDVAL
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// Enable-gated shift-register line buffer with a single tap at the far end.
// Storage has no reset; stale contents are masked by the filter's frame logic.
module line_buffer #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 1280
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tap
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign tap = mem_q[DEPTH-1];

endmodule

// File: rtl/sobel_filter.sv
// 3x3 Sobel gradient filter, 3-cycle pipeline. Build with SOBEL_ABS_EN to show
// edges of both polarities (absolute value); otherwise negative sums clamp to 0.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int LINE_W = 1280
) (
  input  logic iCLK,
  input  logic iRST,
  sobel_if.slave pix
);

  function automatic sum_t ext(input logic [PIX_W-1:0] p);
    return sum_t'({{(SUM_W-PIX_W){1'b0}}, p});
  endfunction

  function automatic sum_t wsum(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                input logic [PIX_W-1:0] c);
    return ext(a) + (ext(b) <<< 1) + ext(c);
  endfunction

  function automatic logic [PIX_W-1:0] sat(input sum_t m);
    return (m > sum_t'(PIX_MAX)) ? PIX_W'(PIX_MAX) : PIX_W'(m);
  endfunction

  function automatic logic [PIX_W-1:0] post_proc(input sum_t s);
    sum_t m;
`ifdef SOBEL_ABS_EN
    m = (s < 0) ? -s : s;
`else
    m = (s < 0) ? sum_t'(0) : s;
`endif
    return sat(m);
  endfunction

  logic [PIX_W-1:0] buf0_tap, buf1_tap;

  line_buffer #(.WIDTH(PIX_W), .DEPTH(LINE_W)) u_buf0 (
    .clk(iCLK), .en(pix.iDVAL), .din(pix.iDATA), .tap(buf0_tap));
  line_buffer #(.WIDTH(PIX_W), .DEPTH(LINE_W)) u_buf1 (
    .clk(iCLK), .en(pix.iDVAL), .din(buf0_tap), .tap(buf1_tap));

  state_t state_q, state_d;
  logic   accept;

  // Validity is decided at the input so a pixel accepted before SOF never reaches the output.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      WAIT_SOF: if (pix.iDVAL && pix.iX_Cont == '0 && pix.iY_Cont == '0) begin
        state_d = RUN;
        accept  = 1'b1;
      end
      RUN:      accept = pix.iDVAL;
      default:  state_d = WAIT_SOF;
    endcase
  end

  // S1: window update
  logic [PIX_W-1:0]   win_q [3][3];
  logic [PIX_W-1:0]   win_d [3][3];
  logic               vld_p1_q, vld_p1_d;
  logic [COORD_W-1:0] x_p1_q, y_p1_q;
  ker_sel_t           sel_p1_q;

  always_comb begin
    win_d = win_q;
    if (pix.iDVAL) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 2; c++) win_d[r][c] = win_q[r][c+1];
      win_d[0][2] = buf1_tap;
      win_d[1][2] = buf0_tap;
      win_d[2][2] = pix.iDATA;
    end
    vld_p1_d = accept;
  end

  // S2: positive/negative partial sums of the selected kernel
  sum_t               pos_p2_q, pos_p2_d, neg_p2_q, neg_p2_d;
  logic               vld_p2_q;
  logic [COORD_W-1:0] x_p2_q, y_p2_q;

  always_comb begin
    if (sel_p1_q == KER_GX) begin
      pos_p2_d = wsum(win_q[0][2], win_q[1][2], win_q[2][2]);
      neg_p2_d = wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
    end else begin
      pos_p2_d = wsum(win_q[2][0], win_q[2][1], win_q[2][2]);
      neg_p2_d = wsum(win_q[0][0], win_q[0][1], win_q[0][2]);
    end
  end

  // S3: final sum, magnitude, saturation and border blanking
  logic [PIX_W-1:0]   odata_q, odata_d;
  logic [COORD_W-1:0] ox_q, oy_q;
  logic               odval_q;
  sum_t               sum_p3;
  logic               border_p3;

  always_comb begin
    sum_p3    = pos_p2_q - neg_p2_q;
    border_p3 = (x_p2_q < COORD_W'(2)) || (y_p2_q < COORD_W'(2));
    odata_d   = border_p3 ? '0 : post_proc(sum_p3);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= WAIT_SOF;
      win_q    <= '{default: '0};
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      odata_q  <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      odval_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p1_q;
      odata_q  <= odata_d;
      ox_q     <= x_p2_q;
      oy_q     <= y_p2_q;
      odval_q  <= vld_p2_q;
    end
  end

  always_ff @(posedge iCLK) begin
    x_p1_q   <= pix.iX_Cont;
    y_p1_q   <= pix.iY_Cont;
    sel_p1_q <= ker_sel_t'(pix.iSel);
    pos_p2_q <= pos_p2_d;
    neg_p2_q <= neg_p2_d;
    x_p2_q   <= x_p1_q;
    y_p2_q   <= y_p1_q;
  end

  assign pix.oDATA   = odata_q;
  assign pix.oX_Cont = ox_q;
  assign pix.oY_Cont = oy_q;
  assign pix.oDVAL   = odval_q;

endmodule

// File: tb/tb_sobel_filter.sv
// Directed bench for sobel_filter on an 8x4 frame; an image-level Sobel model
// supplies the expected output stream, compared every cycle oDVAL is high.
module tb_sobel_filter;
  import sobel_pkg::*;

  localparam int LW = 8;
  localparam int FH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_if bus();

  sobel_filter #(.LINE_W(LW)) dut (
    .iCLK(clk),
    .iRST(rst),
    .pix (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int out_cnt;
  bit running = 1'b0;
  int img [FH][LW];
  int got [FH][LW];
  int q_x[$], q_y[$], q_d[$], q_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Convolve the stored image with the Sobel kernel, then fold sign and saturate.
  function automatic int model_px(input int x, input int y, input bit sel);
    int s = 0;
    int w;
    if (x < 2 || y < 2) return 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        if (!sel) w = (c - 1) * ((r == 1) ? 2 : 1);
        else      w = (r - 1) * ((c == 1) ? 2 : 1);
        s += w * img[y-2+r][x-2+c];
      end
`ifdef SOBEL_ABS_EN
    if (s < 0) s = -s;
`else
    if (s < 0) s = 0;
`endif
    if (s > PIX_MAX) s = PIX_MAX;
    return s;
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    bus.iDVAL   = 1'b0;
    bus.iDATA   = PIX_W'($urandom);
    bus.iX_Cont = COORD_W'($urandom);
    bus.iY_Cont = COORD_W'($urandom);
    bus.iSel    = 1'($urandom);
  endtask

  task automatic send_px(input int x, input int y, input int d, input bit sel);
    @(posedge clk); #1;
    bus.iDVAL   = 1'b1;
    bus.iX_Cont = COORD_W'(x);
    bus.iY_Cont = COORD_W'(y);
    bus.iDATA   = PIX_W'(d);
    bus.iSel    = sel;
    if (x == 0 && y == 0) running = 1'b1;
    if (running) begin
      q_x.push_back(x);
      q_y.push_back(y);
      q_d.push_back(model_px(x, y, sel));
      q_c.push_back(cyc);
    end
  endtask

  task automatic send_frame(input bit sel, input int gap_pct);
    out_cnt = 0;
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < LW; x++) got[y][x] = -1;
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < LW; x++) begin
        for (int g = 0; g < 3; g++)
          if ($urandom_range(99) < gap_pct) idle();
        send_px(x, y, img[y][x], sel);
      end
    repeat (6) idle();
  endtask

  always @(negedge clk) begin : compare
    int ex, ey, ed, ec;
    if (bus.oDVAL) begin
      if (q_d.size() == 0) begin
        check("unexpected_odval", 1, 0);
      end else begin
        ex = q_x.pop_front();
        ey = q_y.pop_front();
        ed = q_d.pop_front();
        ec = q_c.pop_front();
        check("odata", int'(bus.oDATA), ed);
        check("ox", int'(bus.oX_Cont), ex);
        check("oy", int'(bus.oY_Cont), ey);
        check("latency", cyc - ec, 3);
        got[ey][ex] = int'(bus.oDATA);
        out_cnt++;
      end
    end else if (q_c.size() > 0 && cyc > q_c[0] + 3) begin
      check("missing_odval", 0, 1);
      void'(q_x.pop_front());
      void'(q_y.pop_front());
      void'(q_d.pop_front());
      void'(q_c.pop_front());
    end
  end

  task automatic fill(input int v_lo, input int v_hi, input bit by_col);
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < LW; x++)
        img[y][x] = by_col ? ((x < 4) ? v_lo : v_hi) : ((y < 2) ? v_lo : v_hi);
  endtask

  initial begin
    bus.iDVAL   = 1'b0;
    bus.iDATA   = '0;
    bus.iX_Cont = '0;
    bus.iY_Cont = '0;
    bus.iSel    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_odval", int'(bus.oDVAL), 0);
    check("rst_odata", int'(bus.oDATA), 0);
    check("rst_ox", int'(bus.oX_Cont), 0);
    check("rst_oy", int'(bus.oY_Cont), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) idle();

    fill(100, 100, 1'b1);
    send_frame(1'b0, 0);
    check("flat_gx_count", out_cnt, 32);
    check("flat_gx_3_5", got[3][5], 0);
    send_frame(1'b1, 0);
    check("flat_gy_count", out_cnt, 32);
    check("flat_gy_2_4", got[2][4], 0);

    fill(0, 1000, 1'b1);
    send_frame(1'b0, 0);
    check("vstep_2_4", got[2][4], 4000);
    check("vstep_3_5", got[3][5], 4000);
    check("vstep_2_6", got[2][6], 0);
    check("vstep_border_1_4", got[1][4], 0);

    fill(4095, 0, 1'b1);
    send_frame(1'b0, 0);
`ifdef SOBEL_ABS_EN
    check("fall_2_4", got[2][4], 4095);
`else
    check("fall_2_4", got[2][4], 0);
`endif

    fill(0, 500, 1'b0);
    send_frame(1'b1, 0);
    check("hstep_gy_2_3", got[2][3], 2000);
    check("hstep_gy_3_7", got[3][7], 2000);
    send_frame(1'b0, 0);
    check("hstep_gx_2_3", got[2][3], 0);

    fill(0, 1000, 1'b1);
    send_frame(1'b0, 30);
    check("gaps_count", out_cnt, 32);
    check("gaps_2_4", got[2][4], 4000);
    check("gaps_3_5", got[3][5], 4000);

    for (int p = 0; p < 2 * LW + 5; p++) send_px(p % LW, p / LW, img[p / LW][p % LW], 1'b0);
    @(posedge clk); #1;
    bus.iDVAL = 1'b0;
    rst = 1'b1;
    running = 1'b0;
    q_x.delete(); q_y.delete(); q_d.delete(); q_c.delete();
    #1;
    check("midrst_odval", int'(bus.oDVAL), 0);
    check("midrst_ox", int'(bus.oX_Cont), 0);
    check("midrst_oy", int'(bus.oY_Cont), 0);
    check("midrst_odata", int'(bus.oDATA), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_cnt = 0;
    for (int p = 2 * LW + 5; p < FH * LW; p++) send_px(p % LW, p / LW, img[p / LW][p % LW], 1'b0);
    repeat (6) idle();
    check("resume_no_output", out_cnt, 0);
    send_frame(1'b0, 0);
    check("after_sof_count", out_cnt, 32);
    check("after_sof_2_4", got[2][4], 4000);

    check("queue_empty", q_d.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
